ap_ctrl_initiator: RTL



---
 rtl/ap_ctrl_pkg.sv | 23 ++
 rtl/ap_ctrl_sync_fifo.sv | 69 ++++++
 rtl/ap_ctrl_initiator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg
// Shared types and default widths for the ap_ctrl_chain initiator.
//   state_e   : run-level FSM states of the initiator
//   CNT_W_DEF : default width of transaction counts
//   LAT_W_DEF : default width of the cycle timer and latency results
//   cnt_t     : transaction count at the default width
//   lat_t     : latency / timestamp at the default width
package ap_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int LAT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_e;

    typedef logic [CNT_W_DEF-1:0] cnt_t;
    typedef logic [LAT_W_DEF-1:0] lat_t;

endpackage

// File: rtl/ap_ctrl_sync_fifo.sv
// ap_ctrl_sync_fifo
// Small synchronous first-word-fall-through FIFO.
//   clock, reset : system clock, synchronous active-high reset
//   push         : write push_data (ignored when full, unless popping too)
//   push_data    : WIDTH-bit write data
//   pop          : drop the head entry (ignored when empty)
//   pop_data     : head entry, valid whenever empty is low
//   full, empty  : occupancy flags
// A push and a pop in the same cycle are both honoured, also when full.
module ap_ctrl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: the storage array is deliberately not reset; only the pointers and
    // the count decide which entries are meaningful.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_initiator.sv
// ap_ctrl_initiator
// Driving end of an ap_ctrl_chain / ap_ctrl_hs handshake. Launches a commanded
// number of transactions into an HLS core, applies ap_continue backpressure
// and streams out each transaction's start-to-done latency in cycles.
//   clock, reset          : system clock, synchronous active-high reset
//   cmd_valid/ready/count : run request (accepted only in IDLE)
//   ap_start/ready        : launch handshake towards the core
//   ap_done/continue      : completion handshake from the core
//   lat_valid/ready/data  : latency result stream
//   busy, run_done        : run status, one-cycle end-of-run pulse
//   started_cnt, done_cnt : transactions accepted / completed in this run
module ap_ctrl_initiator
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LAT_W        = LAT_W_DEF,
    parameter int MAX_INFLIGHT = 4,
    parameter int RES_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             lat_valid,
    input  logic             lat_ready,
    output logic [LAT_W-1:0] lat_data,
    output logic             busy,
    output logic             run_done,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt
);

    state_e           state;
    logic [CNT_W-1:0] count_q;
    logic [LAT_W-1:0] timer;
    logic [LAT_W-1:0] ts_start;
    logic             accept;
    logic             complete;
    logic             if_push;
    logic             if_full;
    logic             if_empty;
    logic [LAT_W-1:0] if_head;
    logic             res_full;
    logic             res_empty;
    logic [LAT_W-1:0] res_head;
    logic [LAT_W-1:0] lat_calc;
    logic [CNT_W-1:0] started_nxt;
    logic [CNT_W-1:0] done_nxt;
    logic [CNT_W-1:0] inflight_nxt;

    assign accept      = ap_start && ap_ready;
    assign ap_continue = !res_full;
    // An ap_done with nothing in flight is a protocol error and is dropped.
    assign complete    = ap_done && ap_continue && !if_empty;
    assign if_push     = accept && (!if_full || complete);
    // Modular subtraction keeps the result correct across a timer wrap.
    assign lat_calc    = timer - if_head;

    assign started_nxt  = started_cnt + CNT_W'(accept);
    assign done_nxt     = done_cnt + CNT_W'(complete);
    assign inflight_nxt = started_nxt - done_nxt;

    assign lat_valid = !res_empty;
    assign lat_data  = lat_valid ? res_head : '0;

    ap_ctrl_sync_fifo #(.WIDTH(LAT_W), .DEPTH(MAX_INFLIGHT)) u_inflight (
        .clock     (clock),
        .reset     (reset),
        .push      (if_push),
        .push_data (ts_start),
        .pop       (complete),
        .pop_data  (if_head),
        .full      (if_full),
        .empty     (if_empty)
    );

    ap_ctrl_sync_fifo #(.WIDTH(LAT_W), .DEPTH(RES_DEPTH)) u_result (
        .clock     (clock),
        .reset     (reset),
        .push      (complete),
        .push_data (lat_calc),
        .pop       (lat_valid && lat_ready),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty)
    );

    // NOTE: all state here is updated with non-blocking assignments, so every
    // branch reads the pre-edge register values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            ap_start    <= 1'b0;
            count_q     <= '0;
            started_cnt <= '0;
            done_cnt    <= '0;
            timer       <= '0;
            ts_start    <= '0;
        end else begin
            timer    <= timer + LAT_W'(1);
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        count_q     <= cmd_count;
                        started_cnt <= '0;
                        done_cnt    <= '0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_count == '0) begin
                            state    <= FIN;
                            run_done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            ap_start <= 1'b1;
                            // Timestamp = timer value in ap_start's first high cycle.
                            ts_start <= timer + LAT_W'(1);
                        end
                    end
                end
                RUN: begin
                    started_cnt <= started_nxt;
                    done_cnt    <= done_nxt;
                    // A pending start is held until accepted, never withdrawn.
                    if (!ap_start || ap_ready) begin
                        if (started_nxt < count_q &&
                            inflight_nxt < CNT_W'(MAX_INFLIGHT)) begin
                            ap_start <= 1'b1;
                            ts_start <= timer + LAT_W'(1);
                        end else begin
                            ap_start <= 1'b0;
                        end
                    end
                    if (started_nxt == count_q) state <= DRAIN;
                end
                DRAIN: begin
                    done_cnt <= done_nxt;
                    if (done_nxt == count_q) begin
                        state    <= FIN;
                        run_done <= 1'b1;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
